// File: rtl/ysyx_22040895_imem_pkg.sv
// Shared constants and state encoding for the instruction-memory responder.
// The state values match the 2-bit Idle/Wait/Resp encodings used elsewhere in the core.
package ysyx_22040895_imem_pkg;

    localparam logic [63:0] ysyx_22040895_ImemBase = 64'h8000_0000;
    localparam int          IMEM_CNT_W             = 4;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'b00,
        IMEM_WAIT = 2'b01,
        IMEM_RESP = 2'b10
    } imem_state_e;

endpackage

// File: rtl/ysyx_22040895_imem_array.sv
// Word-wide instruction storage: one synchronous read port, one synchronous write port.
// A read and a write to the same word on the same edge return the old contents.
module ysyx_22040895_imem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = 12
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Both ports sit in one process so the read samples the pre-write value.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/ysyx_22040895_imem.sv
// Instruction-memory responder: accepts one fetch per request handshake and
// returns the word after LATENCY cycles, held until the fetch side takes it.
//
// Handshakes: a request transfers on an edge where req_valid_i && req_ready_o;
// a response transfers on an edge where resp_valid_o && resp_ready_i. Once
// resp_valid_o rises, resp_inst_o/resp_err_o hold until that transfer.
module ysyx_22040895_imem
    import ysyx_22040895_imem_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = ysyx_22040895_ImemBase,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [63:0] req_addr_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_inst_o,
    output logic        resp_err_o,
    input  logic        ld_we_i,
    input  logic [63:0] ld_addr_i,
    input  logic [31:0] ld_data_i
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    imem_state_e           state, state_next;
    logic [IMEM_CNT_W-1:0] cnt, cnt_next;
    logic [63:0]           addr_q, addr_next;
    logic                  capture;
    logic [31:0]           rd_data;
    logic [63:0]           rd_addr;

    function automatic logic addr_ok(input logic [63:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) &&
               (((a - BASE_ADDR) >> 2) < 64'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [63:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IMEM_IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            addr_q <= addr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_next  = addr_q;
        capture    = 1'b0;
        case (state)
            IMEM_IDLE: begin
                if (req_valid_i) begin
                    addr_next = req_addr_i;
                    cnt_next  = IMEM_CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_next = IMEM_RESP;
                        capture    = 1'b1;
                    end else begin
                        state_next = IMEM_WAIT;
                    end
                end
            end
            IMEM_WAIT: begin
                cnt_next = cnt - IMEM_CNT_W'(1);
                if (cnt == IMEM_CNT_W'(1)) begin
                    state_next = IMEM_RESP;
                    capture    = 1'b1;
                end
            end
            IMEM_RESP: begin
                if (resp_ready_i) begin
                    state_next = IMEM_IDLE;
                end
            end
            default: state_next = IMEM_IDLE;
        endcase
    end

    // With single-cycle latency the capture happens on the accept edge, so the
    // read must index with the incoming address rather than the latched one.
    assign rd_addr = (state == IMEM_IDLE) ? req_addr_i : addr_q;

    ysyx_22040895_imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .rd_en   (capture && !rst),
        .rd_idx  (idx_of(rd_addr)),
        .rd_data (rd_data),
        .wr_en   (ld_we_i && addr_ok(ld_addr_i)),
        .wr_idx  (idx_of(ld_addr_i)),
        .wr_data (ld_data_i)
    );

    assign req_ready_o  = (state == IMEM_IDLE);
    assign resp_valid_o = (state == IMEM_RESP);
    assign resp_err_o   = (state == IMEM_RESP) && !addr_ok(addr_q);
    assign resp_inst_o  = ((state == IMEM_RESP) && addr_ok(addr_q)) ? rd_data : 32'h0;

endmodule

// File: tb/tb_ysyx_22040895_imem.sv
// Directed bench for the instruction-memory responder: one instance at latency 1
// and one at latency 4, each with its own stimulus signals.
module tb_ysyx_22040895_imem;

    logic        clk;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [63:0] req_addr   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_inst  [2];
    logic        resp_err   [2];
    logic        ld_we      [2];
    logic [63:0] ld_addr    [2];
    logic [31:0] ld_data    [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    ysyx_22040895_imem #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_inst_o(resp_inst[0]), .resp_err_o(resp_err[0]),
        .ld_we_i(ld_we[0]), .ld_addr_i(ld_addr[0]), .ld_data_i(ld_data[0])
    );

    ysyx_22040895_imem #(.LATENCY(4)) dut_l4 (
        .clk(clk), .rst(rst[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_inst_o(resp_inst[1]), .resp_err_o(resp_err[1]),
        .ld_we_i(ld_we[1]), .ld_addr_i(ld_addr[1]), .ld_data_i(ld_data[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input int d, input logic [63:0] a, input logic [31:0] data);
        ld_we[d]   = 1'b1;
        ld_addr[d] = a;
        ld_data[d] = data;
        @(negedge clk);
        ld_we[d] = 1'b0;
    endtask

    // Issues one request with resp_ready held high and checks latency, data and turnaround.
    task automatic fetch(input int d, input int lat, input logic [63:0] a,
                         input logic [31:0] e_inst, input logic e_err, input string nm);
        int k;
        bit ready_low;
        check({nm, " ready_before"}, 64'(req_ready[d]), 64'd1);
        req_valid[d]  = 1'b1;
        req_addr[d]   = a;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        k = 0;
        ready_low = 1'b1;
        while (!resp_valid[d] && k < 20) begin
            if (req_ready[d]) ready_low = 1'b0;
            @(negedge clk);
            k++;
        end
        check({nm, " latency"}, 64'(k), 64'(lat - 1));
        if (lat > 1) check({nm, " ready_low_wait"}, 64'(ready_low), 64'd1);
        check({nm, " ready_low_resp"}, 64'(req_ready[d]), 64'd0);
        check({nm, " inst"}, 64'(resp_inst[d]), 64'(e_inst));
        check({nm, " err"}, 64'(resp_err[d]), 64'(e_err));
        @(negedge clk);
        check({nm, " valid_drop"}, 64'(resp_valid[d]), 64'd0);
        check({nm, " ready_after"}, 64'(req_ready[d]), 64'd1);
    endtask

    initial begin
        vecs[0] = '{64'h0000_0000_8000_0000, 32'h0000_0413, 1'b0};
        vecs[1] = '{64'h0000_0000_8000_0004, 32'h0010_0093, 1'b0};
        vecs[2] = '{64'h0000_0000_8000_3FFC, 32'h1234_5678, 1'b0};
        vecs[3] = '{64'h0000_0000_8000_0002, 32'h0000_0000, 1'b1};
        vecs[4] = '{64'h0000_0000_7FFF_FFFC, 32'h0000_0000, 1'b1};
        vecs[5] = '{64'h0000_0000_8000_4000, 32'h0000_0000, 1'b1};
        vecs[6] = '{64'h0000_0000_8000_0003, 32'h0000_0000, 1'b1};
        vecs[7] = '{64'h0000_0000_0000_0000, 32'h0000_0000, 1'b1};
        vecs[8] = '{64'h0000_0001_8000_0000, 32'h0000_0000, 1'b1};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0; resp_ready[d] = 1'b0;
            ld_we[d] = 1'b0; ld_addr[d] = '0; ld_data[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset ready", 64'(req_ready[d]), 64'd1);
            check("reset valid", 64'(resp_valid[d]), 64'd0);
            check("reset inst", 64'(resp_inst[d]), 64'd0);
            check("reset err", 64'(resp_err[d]), 64'd0);
            rst[d] = 1'b0;
        end

        // Preload; the two illegal writes would alias onto words 1 and 0 if not dropped.
        load(0, 64'h8000_0000, 32'h0000_0413);
        load(0, 64'h8000_0004, 32'h0010_0093);
        load(0, 64'h8000_0008, 32'h1111_1111);
        load(0, 64'h8000_3FFC, 32'h1234_5678);
        load(0, 64'h8000_0006, 32'hFFFF_FFFF);
        load(0, 64'h8000_4000, 32'hEEEE_EEEE);
        load(1, 64'h8000_0004, 32'hCAFE_F00D);

        for (int i = 0; i < 9; i++) begin
            fetch(0, 1, vecs[i].addr, vecs[i].inst, vecs[i].err, $sformatf("vec%0d", i));
        end

        fetch(1, 4, 64'h8000_0004, 32'hCAFE_F00D, 1'b0, "l4_word1");
        fetch(1, 4, 64'h8000_0002, 32'h0000_0000, 1'b1, "l4_misaligned");

        // Back-pressure: response held five cycles while new requests are offered.
        req_valid[0] = 1'b1; req_addr[0] = 64'h8000_0000; resp_ready[0] = 1'b0;
        @(negedge clk);
        req_addr[0] = 64'h8000_0004;
        check("hold first_valid", 64'(resp_valid[0]), 64'd1);
        check("hold first_inst", 64'(resp_inst[0]), 64'h413);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold valid c%0d", i), 64'(resp_valid[0]), 64'd1);
            check($sformatf("hold inst c%0d", i), 64'(resp_inst[0]), 64'h413);
            check($sformatf("hold err c%0d", i), 64'(resp_err[0]), 64'd0);
            check($sformatf("hold ready c%0d", i), 64'(req_ready[0]), 64'd0);
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        check("release valid", 64'(resp_valid[0]), 64'd0);
        check("release ready", 64'(req_ready[0]), 64'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("next_req valid", 64'(resp_valid[0]), 64'd1);
        check("next_req inst", 64'(resp_inst[0]), 64'h0010_0093);
        @(negedge clk);

        // Loader write lands on the same edge the response word is captured.
        req_valid[0] = 1'b1; req_addr[0] = 64'h8000_0008; resp_ready[0] = 1'b1;
        ld_we[0] = 1'b1; ld_addr[0] = 64'h8000_0008; ld_data[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid[0] = 1'b0; ld_we[0] = 1'b0;
        check("collide valid", 64'(resp_valid[0]), 64'd1);
        check("collide old_data", 64'(resp_inst[0]), 64'h1111_1111);
        @(negedge clk);
        fetch(0, 1, 64'h8000_0008, 32'hDEAD_BEEF, 1'b0, "refetch");

        // Reset in the middle of a latency-4 wait drops the transaction.
        begin
            bit stale;
            req_valid[1] = 1'b1; req_addr[1] = 64'h8000_0004; resp_ready[1] = 1'b1;
            @(negedge clk);
            req_valid[1] = 1'b0;
            @(negedge clk);
            check("midwait ready_low", 64'(req_ready[1]), 64'd0);
            rst[1] = 1'b1;
            @(negedge clk);
            rst[1] = 1'b0;
            check("rst_wait valid", 64'(resp_valid[1]), 64'd0);
            check("rst_wait ready", 64'(req_ready[1]), 64'd1);
            check("rst_wait inst", 64'(resp_inst[1]), 64'd0);
            check("rst_wait err", 64'(resp_err[1]), 64'd0);
            stale = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (resp_valid[1]) stale = 1'b1;
            end
            check("rst_wait no_stale", 64'(stale), 64'd0);
            fetch(1, 4, 64'h8000_0004, 32'hCAFE_F00D, 1'b0, "rst_wait mem_kept");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
